// File: rtl/wire_to_axis.sv
// wire_to_axis: turns a free-running parallel word into an AXI4-Stream master.
// A beat is produced whenever the word changes, on a force strobe, or on an
// optional periodic tick. While the sink stalls, further updates collapse into
// a one-deep pending slot (newest wins), and every overwritten value is
// counted in a saturating 16-bit overrun counter.
module wire_to_axis #(
   parameter int IN_WIDTH         = 32,
   parameter int AXIS_TDATA_WIDTH = 32,
   parameter int PERIOD           = 0
) (
   input  logic                        aclk,
   input  logic                        aresetn,
   input  logic [IN_WIDTH-1:0]         data,
   input  logic                        force_i,
   output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
   output logic                        m_axis_tvalid,
   input  logic                        m_axis_tready,
   output logic [15:0]                 overrun_count
);

   // Timer width covers 0..PERIOD-1; at least one bit so the vector is legal.
   localparam int TW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam logic [TW-1:0] TMAX = TW'((PERIOD == 0) ? 0 : PERIOD - 1);

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   state_t                        state_q,    state_d;
   logic [IN_WIDTH-1:0]           s1_q,       s2_q;
   logic                          force_q;
   logic [TW-1:0]                 timer_q,    timer_d;
   logic [AXIS_TDATA_WIDTH-1:0]   tdata_q,    tdata_d;
   logic [AXIS_TDATA_WIDTH-1:0]   pend_q,     pend_d;
   logic                          pend_vld_q, pend_vld_d;
   logic [15:0]                   ovr_q,      ovr_d;

   logic                          tick;
   logic                          ev;
   logic [AXIS_TDATA_WIDTH-1:0]   payload;

   // Saturating increment: the counter sticks at all-ones instead of wrapping.
   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   assign tick    = (PERIOD != 0) && (timer_q == TMAX);
   assign ev      = (s1_q != s2_q) || force_q || tick;
   assign payload = AXIS_TDATA_WIDTH'(s1_q);

   assign m_axis_tdata  = tdata_q;
   assign m_axis_tvalid = (state_q == SEND);
   assign overrun_count = ovr_q;

   // Two-stage sample of the source word plus a registered force strobe;
   // a change is seen as s1 differing from s2.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         s1_q    <= '0;
         s2_q    <= '0;
         force_q <= 1'b0;
      end else begin
         s1_q    <= data;
         s2_q    <= s1_q;
         force_q <= force_i;
      end
   end

   // Free-running resend timer; independent of stream handshakes.
   always_comb begin
      timer_d = '0;
      if (PERIOD != 0 && !tick) begin
         timer_d = timer_q + TW'(1);
      end
   end

   // State, payload, pending slot and overrun counter registers.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q    <= IDLE;
         timer_q    <= '0;
         tdata_q    <= '0;
         pend_q     <= '0;
         pend_vld_q <= 1'b0;
         ovr_q      <= '0;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         tdata_q    <= tdata_d;
         pend_q     <= pend_d;
         pend_vld_q <= pend_vld_d;
         ovr_q      <= ovr_d;
      end
   end

   // Next-state logic: issue, hold during stalls, coalesce into the pending slot.
   always_comb begin
      state_d    = state_q;
      tdata_d    = tdata_q;
      pend_d     = pend_q;
      pend_vld_d = pend_vld_q;
      ovr_d      = ovr_q;

      unique case (state_q)
         IDLE: begin
            if (ev) begin
               tdata_d = payload;
               state_d = SEND;
            end
         end

         SEND: begin
            if (m_axis_tready) begin
               if (pend_vld_q) begin
                  // Pending value goes out next; a same-cycle event refills it.
                  tdata_d    = pend_q;
                  pend_vld_d = 1'b0;
                  if (ev) begin
                     pend_d     = payload;
                     pend_vld_d = 1'b1;
                  end
               end else if (ev) begin
                  tdata_d = payload;
               end else begin
                  state_d = IDLE;
               end
            end else if (ev) begin
               // Sink stalled: tdata stays put, newest event parks in the slot.
               pend_d     = payload;
               pend_vld_d = 1'b1;
               if (pend_vld_q) begin
                  ovr_d = sat_inc(ovr_q);
               end
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule
